// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: IDLE -> GRANTn -> RESP, one access per three cycles.
// Define DMEM_ARBITER_FIXED_PRIO_EN to make port 0 always win ties (no round-robin pointer).
module dmem_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  w_r0,
  input  logic [ADDR_BITS-1:0]  addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  gnt0,
  output logic                  vld0,
  input  logic                  req1,
  input  logic                  w_r1,
  input  logic [ADDR_BITS-1:0]  addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt1,
  output logic                  vld1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_en,
  output logic                  mem_w_r,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10,
    RESP   = 2'b11
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  w_tie_port1;
  logic                  r_gnt0;
  logic                  r_gnt1;
  logic                  r_vld0;
  logic                  r_vld1;
  logic                  r_mem_en;
  logic                  r_mem_w_r;
  logic [ADDR_BITS-1:0]  r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_port;
  logic                  r_write;

`ifdef DMEM_ARBITER_FIXED_PRIO_EN
  assign w_tie_port1 = 1'b0;
`else
  // r_last_port1 high means port 1 was granted last, so port 0 wins the next tie.
  logic r_last_port1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_port1 <= 1'b1;
    end else if (w_next == GRANT0) begin
      r_last_port1 <= 1'b0;
    end else if (w_next == GRANT1) begin
      r_last_port1 <= 1'b1;
    end
  end

  assign w_tie_port1 = ~r_last_port1;
`endif

  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (req0 && req1) begin
          w_next = w_tie_port1 ? GRANT1 : GRANT0;
        end else if (req0) begin
          w_next = GRANT0;
        end else if (req1) begin
          w_next = GRANT1;
        end
      end
      GRANT0, GRANT1: w_next = RESP;
      RESP:           w_next = IDLE;
      default:        w_next = IDLE;
    endcase
  end

  // Outputs are computed from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (!rst) begin
      r_state     <= IDLE;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_vld0      <= 1'b0;
      r_vld1      <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_w_r   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
      r_port      <= 1'b0;
      r_write     <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_gnt0   <= (w_next == GRANT0);
      r_gnt1   <= (w_next == GRANT1);
      r_mem_en <= (w_next == GRANT0) || (w_next == GRANT1);
      r_vld0   <= (w_next == RESP) && !r_port;
      r_vld1   <= (w_next == RESP) && r_port;
      r_mem_w_r <= 1'b0;
      if (w_next == GRANT0) begin
        r_mem_w_r   <= w_r0;
        r_mem_addr  <= addr0;
        r_mem_wdata <= wdata0;
        r_port      <= 1'b0;
        r_write     <= w_r0;
      end else if (w_next == GRANT1) begin
        r_mem_w_r   <= w_r1;
        r_mem_addr  <= addr1;
        r_mem_wdata <= wdata1;
        r_port      <= 1'b1;
        r_write     <= w_r1;
      end
      if (r_state == RESP && !r_write) begin
        r_rdata <= mem_rdata;
      end
    end
  end

  // The memory's registered read port only becomes valid in RESP, so a read forwards it
  // directly; r_rdata keeps that value for later cycles and across write accesses.
  assign rdata     = (r_state == RESP && !r_write) ? mem_rdata : r_rdata;
  assign gnt0      = r_gnt0;
  assign gnt1      = r_gnt1;
  assign vld0      = r_vld0;
  assign vld1      = r_vld1;
  assign mem_en    = r_mem_en;
  assign mem_w_r   = r_mem_w_r;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a synchronous 32x8 memory model.
// Expectations switch on DMEM_ARBITER_FIXED_PRIO_EN for the tie-break sequence.
module tb_dmem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, w_r0, req1, w_r1;
  logic [4:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, vld0, gnt1, vld1;
  logic [7:0] rdata;
  logic       mem_en, mem_w_r;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic [7:0] mem [32];

  int n_checks = 0;
  int n_errors = 0;

  dmem_arbiter #(.DATA_WIDTH(8), .ADDR_BITS(5)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .w_r0(w_r0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .vld0(vld0),
    .req1(req1), .w_r1(w_r1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .vld1(vld1),
    .rdata(rdata), .mem_en(mem_en), .mem_w_r(mem_w_r), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous memory: read data appears the cycle after mem_en.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_w_r) mem[mem_addr] <= mem_wdata;
      else         mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h80 + 8'(i);
    rst = 1'b0;
    req0 = 0; w_r0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; w_r1 = 0; addr1 = 0; wdata1 = 0;
    step();
    step();
    check("rst_gnt0", gnt0, 0);
    check("rst_gnt1", gnt1, 0);
    check("rst_vld0", vld0, 0);
    check("rst_vld1", vld1, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_w_r", mem_w_r, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_rdata", rdata, 0);
    rst = 1'b1;

    // Port 0 write of 0x3C to address 5.
    req0 = 1; w_r0 = 1; addr0 = 5; wdata0 = 8'h3C;
    step();
    check("w0_gnt0", gnt0, 1);
    check("w0_gnt1", gnt1, 0);
    check("w0_mem_en", mem_en, 1);
    check("w0_mem_w_r", mem_w_r, 1);
    check("w0_mem_addr", mem_addr, 5);
    check("w0_mem_wdata", mem_wdata, 8'h3C);
    check("w0_vld0_early", vld0, 0);
    req0 = 0;
    step();
    check("w0_vld0", vld0, 1);
    check("w0_vld1", vld1, 0);
    check("w0_gnt0_drop", gnt0, 0);
    check("w0_mem_en_drop", mem_en, 0);
    step();
    check("w0_idle_vld0", vld0, 0);

    // Port 1 read back of address 5.
    req1 = 1; w_r1 = 0; addr1 = 5;
    step();
    check("r1_gnt1", gnt1, 1);
    check("r1_gnt0", gnt0, 0);
    check("r1_mem_en", mem_en, 1);
    check("r1_mem_w_r", mem_w_r, 0);
    check("r1_mem_addr", mem_addr, 5);
    req1 = 0;
    step();
    check("r1_vld1", vld1, 1);
    check("r1_vld0", vld0, 0);
    check("r1_rdata", rdata, 8'h3C);
    step();
    check("r1_idle_vld1", vld1, 0);
    check("r1_rdata_hold", rdata, 8'h3C);

    // Both ports requesting continuously: last grant was port 1, so port 0 starts.
    req0 = 1; w_r0 = 0; addr0 = 1;
    req1 = 1; w_r1 = 0; addr1 = 2;
    for (int i = 0; i < 4; i++) begin
      int exp_p;
`ifdef DMEM_ARBITER_FIXED_PRIO_EN
      exp_p = 0;
`else
      exp_p = i % 2;
`endif
      step();
      check($sformatf("tie%0d_gnt0", i), gnt0, (exp_p == 0) ? 1 : 0);
      check($sformatf("tie%0d_gnt1", i), gnt1, (exp_p == 1) ? 1 : 0);
      step();
      check($sformatf("tie%0d_vld0", i), vld0, (exp_p == 0) ? 1 : 0);
      check($sformatf("tie%0d_vld1", i), vld1, (exp_p == 1) ? 1 : 0);
      check($sformatf("tie%0d_rdata", i), rdata, (exp_p == 0) ? 8'h81 : 8'h82);
      step();
      check($sformatf("tie%0d_idle_en", i), mem_en, 0);
    end
    req0 = 0; req1 = 0;

    // Reset pulse in the middle of a port 1 write grant abandons the access.
    req1 = 1; w_r1 = 1; addr1 = 9; wdata1 = 8'hA5;
    step();
    check("rg_gnt1", gnt1, 1);
    rst = 1'b0;
    #1;
    check("rg_gnt1_drop", gnt1, 0);
    check("rg_mem_en_drop", mem_en, 0);
    req1 = 0;
    #1;
    rst = 1'b1;
    step();
    check("rg_no_vld1", vld1, 0);
    check("rg_idle_en", mem_en, 0);
    step();
    check("rg_still_no_vld1", vld1, 0);

    // First tie after reset goes to port 0; port 1 request raised in RESP must wait.
    req0 = 1; w_r0 = 0; addr0 = 5;
    req1 = 1; w_r1 = 0; addr1 = 9;
    step();
    check("post_rst_gnt0", gnt0, 1);
    check("post_rst_gnt1", gnt1, 0);
    req0 = 0; req1 = 0;
    step();
    check("resp_vld0", vld0, 1);
    check("resp_rdata", rdata, 8'h3C);
    req1 = 1;
    step();
    check("resp_ignored_gnt1", gnt1, 0);
    check("resp_ignored_en", mem_en, 0);
    step();
    check("late_gnt1", gnt1, 1);
    check("late_mem_addr", mem_addr, 9);
    req1 = 0;
    step();
    check("late_vld1", vld1, 1);
    check("late_rdata_unwritten", rdata, 8'h89);
    step();

    // A write keeps rdata at its previous value; a later read sees the new data.
    req0 = 1; w_r0 = 1; addr0 = 2; wdata0 = 8'h11;
    step();
    check("w2_gnt0", gnt0, 1);
    req0 = 0;
    step();
    check("w2_vld0", vld0, 1);
    check("w2_rdata_hold", rdata, 8'h89);
    step();
    req1 = 1; w_r1 = 0; addr1 = 2;
    step();
    check("r2_gnt1", gnt1, 1);
    req1 = 0;
    step();
    check("r2_vld1", vld1, 1);
    check("r2_rdata", rdata, 8'h11);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, 8, data bus width.
REQ-002 Parameter: ADDR_BITS, 5, data memory address width (32 words).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 req0  input  1  port 0 (CPU datapath) access request.
REQ-006 w_r0  input  1  port 0 direction: 1 write, 0 read.
REQ-007 addr0  input  ADDR_BITS  port 0 address.
REQ-008 wdata0  input  DATA_WIDTH  port 0 write data.
REQ-009 gnt0  output  1  port 0 grant pulse.
REQ-010 vld0  output  1  port 0 access-complete pulse; rdata valid for reads.
REQ-011 req1  input  1  port 1 (program/debug loader) access request.
REQ-012 w_r1  input  1  port 1 direction: 1 write, 0 read.
REQ-013 addr1  input  ADDR_BITS  port 1 address.
REQ-014 wdata1  input  DATA_WIDTH  port 1 write data.
REQ-015 gnt1  output  1  port 1 grant pulse.
REQ-016 vld1  output  1  port 1 access-complete pulse.
REQ-017 rdata  output  DATA_WIDTH  read data returned to the served port.
REQ-018 mem_en  output  1  memory access strobe.
REQ-019 mem_w_r  output  1  memory direction: 1 write, 0 read.
REQ-020 mem_addr  output  ADDR_BITS  memory address.
REQ-021 mem_wdata  output  DATA_WIDTH  memory write data.
REQ-022 mem_rdata  input  DATA_WIDTH  memory read data; synchronous, valid the cycle after mem_en.

Function
REQ-023 FSM states IDLE, GRANT0, GRANT1, RESP; all outputs registered.
REQ-024 IDLE: only one reqN set -> GRANTN; both set -> winner per REQ-029; none -> stay IDLE.
REQ-025 GRANTN lasts exactly one cycle: gntN=1, mem_en=1, mem_w_r/mem_addr/mem_wdata = port N inputs; then -> RESP.
REQ-026 RESP lasts exactly one cycle: vldN=1 for served port; rdata = mem_rdata on reads, holds previous value on writes; then -> IDLE.
REQ-027 Latency: req sampled at edge N -> gnt high cycle N+1 -> vld high cycle N+2; one access per 3 cycles maximum.
REQ-028 Handshake: requester holds req, w_r, addr, wdata stable until it sees gnt, then deasserts req the following cycle; req is ignored in GRANT and RESP; req dropped before grant withdraws the request without side effects.
REQ-029 Round-robin: last-grant pointer updates on every grant; on simultaneous requests the port not last granted wins.
REQ-030 gnt0/gnt1 and vld0/vld1 are never high together; mem_en is high only in GRANT states.
REQ-031 Undefined state encoding -> IDLE on next edge with all strobes low.

Reset
REQ-032 rst low, asynchronously: state IDLE, gnt0/gnt1/vld0/vld1/mem_en/mem_w_r = 0, mem_addr/mem_wdata/rdata = 0, pointer = port 1 (port 0 wins first tie).
REQ-033 Reset during GRANT or RESP abandons the access: no vld pulse after release; first post-reset decision taken in IDLE.

Configuration
REQ-034 Macro DMEM_ARBITER_FIXED_PRIO_EN defined: port 0 always wins ties, pointer logic absent; port 1 may starve.
REQ-035 Macro undefined: round-robin per REQ-029.

Verification
REQ-036 Reset release, req0=1 w_r0=1 addr0=5 wdata0=0x3C -> gnt0 next cycle with mem_en=1 mem_w_r=1 mem_addr=5 mem_wdata=0x3C; vld0 cycle after.
REQ-037 Port 1 read addr1=5, memory returns 0x3C -> gnt1, then vld1=1 rdata=0x3C.
REQ-038 req0 and req1 held continuously (re-raised after each vld) -> grants alternate 0,1,0,1 (macro undefined); all 0 with DMEM_ARBITER_FIXED_PRIO_EN.
REQ-039 rst pulsed low during GRANT1 -> mem_en and gnt1 drop immediately, no vld1, next tie grants port 0.
REQ-040 req1 asserted during RESP of port 0 access -> ignored until IDLE, gnt1 exactly 2 cycles after vld0.
